// File: rtl/io_display_arbiter_pkg.sv
// Shared types and constants for the display arbiter: scan states, requester ids, idle patterns.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package io_display_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    typedef enum logic {
        PROC = 1'b0,
        DBG  = 1'b1
    } req_id_t;

    // Anodes and segments are both active-low, so "all off" is all ones.
    localparam logic [2:0] AN_OFF  = 3'b111;
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/io_display_arbiter_if.sv
// Display-write request bus: processor and debug requesters, each a valid/ready pair with data.
// Latency: n/a (wiring only).
// Backpressure: requester holds valid/data until it sees ready high in the same cycle.
// Ports: master = requester side (drives valid/data), slave = arbiter side (drives ready).
interface io_display_arbiter_if #(
    parameter int WIDTH = 12
);
    logic             proc_valid;
    logic [WIDTH-1:0] proc_data;
    logic             proc_ready;
    logic             dbg_valid;
    logic [WIDTH-1:0] dbg_data;
    logic             dbg_ready;

    modport master (
        output proc_valid, proc_data, dbg_valid, dbg_data,
        input  proc_ready, dbg_ready
    );

    modport slave (
        input  proc_valid, proc_data, dbg_valid, dbg_data,
        output proc_ready, dbg_ready
    );
endinterface

// File: rtl/hex_to_7seg.sv
// Hex nibble to seven-segment glyph, segments {g,f,e,d,c,b,a}, active-low.
// Latency: combinational.
// Backpressure: none.
// Ports: nibble in (4), seg out (7).
module hex_to_7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'h7F;
        endcase
    end
endmodule

// File: rtl/io_display_arbiter.sv
// Arbitrates processor/debug display writes round-robin, holds the shown value, scans 3 digits.
// Latency: grant to shown 1 cycle; switches 2 cycles; scan slot SCAN_DIV drive + 1 blank cycle.
// Backpressure: ready is combinational; freeze (sw[0]) or debug-disable (sw[1]=0) holds ready low.
// Ports: clock, reset (async active-low), sw[1:0], bus (slave modport), io_display[6:0], an[2:0], shown.
module io_display_arbiter
    import io_display_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int WIDTH    = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          sw,
    io_display_arbiter_if.slave bus,
    output logic [6:0]          io_display,
    output logic [2:0]          an,
    output logic [WIDTH-1:0]    shown
);
    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // Switch synchronizer
    logic [1:0] sw_meta;
    logic [1:0] sw_sync;
    logic       frz_s;
    logic       dbg_en_s;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta <= 2'b00;
            sw_sync <= 2'b00;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    assign frz_s    = sw_sync[0];
    assign dbg_en_s = sw_sync[1];

    // Arbitration
    req_id_t prio;
    logic    proc_elig;
    logic    dbg_elig;
    logic    grant_proc;
    logic    grant_dbg;

    assign proc_elig = bus.proc_valid && !frz_s;
    assign dbg_elig  = bus.dbg_valid && dbg_en_s && !frz_s;

    // Gating with reset keeps both readys low while reset is asserted,
    // even if a requester is already presenting valid.
    always_comb begin
        grant_proc = 1'b0;
        grant_dbg  = 1'b0;
        if (reset) begin
            if (proc_elig && dbg_elig) begin
                if (prio == PROC) begin
                    grant_proc = 1'b1;
                end else begin
                    grant_dbg = 1'b1;
                end
            end else begin
                grant_proc = proc_elig;
                grant_dbg  = dbg_elig;
            end
        end
    end

    assign bus.proc_ready = grant_proc;
    assign bus.dbg_ready  = grant_dbg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shown <= '0;
            prio  <= PROC;
        end else if (grant_proc) begin
            shown <= bus.proc_data;
            prio  <= DBG;
        end else if (grant_dbg) begin
            shown <= bus.dbg_data;
            prio  <= PROC;
        end
    end

    // Scan FSM
    scan_state_t      state;
    scan_state_t      state_nxt;
    logic [1:0]       digit;
    logic [1:0]       digit_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       nibble;
    logic [6:0]       seg_dec;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= BLANK;
            digit <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            digit <= digit_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        digit_nxt  = digit;
        cnt_nxt    = cnt;
        an         = AN_OFF;
        io_display = SEG_OFF;
        case (state)
            BLANK: begin
                state_nxt = DRIVE;
                cnt_nxt   = '0;
            end
            DRIVE: begin
                case (digit)
                    2'd0:    an = 3'b110;
                    2'd1:    an = 3'b101;
                    2'd2:    an = 3'b011;
                    default: an = AN_OFF;
                endcase
                io_display = seg_dec;
                if (cnt == CNT_LAST) begin
                    digit_nxt = (digit == 2'd2) ? 2'd0 : digit + 2'd1;
                    state_nxt = BLANK;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = BLANK;
        endcase
    end

    always_comb begin
        nibble = shown[3:0];
        case (digit)
            2'd1:    nibble = shown[7:4];
            2'd2:    nibble = shown[11:8];
            default: nibble = shown[3:0];
        endcase
    end

    hex_to_7seg u_hex (
        .nibble (nibble),
        .seg    (seg_dec)
    );

endmodule

// File: doc/io_display_arbiter.md
# io_display_arbiter

Owns the 3-digit seven-segment display on the FPGA device. It arbitrates display-write requests from the pipelined processor's IO port and from a debug source, holds the shown 12-bit value, and drives the multiplexed scan of segments (`io_display`) and anodes (`an`). The board switches `sw[1:0]` set freeze and debug-enable behaviour. It sits between the processor core and the board pins inside `FPGADevice`.

## Interface
- `SCAN_DIV`, default 4: clock cycles each digit is driven per scan slot (minimum 2).
- `WIDTH`, default 12: display value width, 3 hex digits (fixed at 12).
- `clock` input 1: single system clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low.
- `sw` input 2: raw board switches.
  - `sw[0]`: freeze.
  - `sw[1]`: debug enable.
- `proc_valid` input 1: processor has a display write pending.
- `proc_data` input 12: processor write value.
- `proc_ready` output 1: processor write accepted this cycle.
- `dbg_valid` input 1: debug write pending.
- `dbg_data` input 12: debug write value.
- `dbg_ready` output 1: debug write accepted this cycle.
- `io_display` output 7: segments {g,f,e,d,c,b,a}, active-low.
- `an` output 3: digit anodes, active-low, one-hot-low when driving.
- `shown` output 12: currently held display value, for debug/visibility.

## Operation
- **Switch synchronizer.** `sw` passes through a 2-flop synchronizer to give `frz_s` and `dbg_en_s`. These are reset to 0.
- **Handshake.** A requester raises `valid` with data and must hold both stable until it sees `ready` high. A transfer occurs on any cycle where `valid && ready`.
- **Eligibility.**
  - proc is eligible when `proc_valid && !frz_s`.
  - dbg is eligible when `dbg_valid && dbg_en_s && !frz_s`.
- **Grant rules.** `ready` is combinational from `valid`, the synced switches, and the priority pointer `prio`. At most one grant per cycle.
  - Only one requester eligible: it is granted.
  - Both eligible: the requester indicated by `prio` is granted.
  - After any grant, `prio` points to the other requester (round-robin).
  - `prio` resets to proc.
- **Held value.** On a grant, `shown <= granted data` at the next edge. `shown` resets to 12'h000.
- **Freeze.** While `frz_s` is 1, both `ready` outputs stay low. Pending requests wait and no data is lost. Scanning continues and shows the held value.
- **Debug disabled.** When `dbg_en_s` is 0, `dbg_ready` stays 0.
- **Scan FSM.** States are BLANK and DRIVE. State also includes `digit` (0..2) and `cnt`.
  - BLANK: `an = 3'b111`, `io_display = 7'h7F`. Lasts 1 cycle, then goes to DRIVE with `cnt = 0`.
  - DRIVE: `an` drives the current digit low.
    - digit 0 → `an = 3'b110`, showing `shown[3:0]`.
    - digit 1 → `an = 3'b101`, showing `shown[7:4]`.
    - digit 2 → `an = 3'b011`, showing `shown[11:8]`.
  - `io_display` is the hex decode of the selected nibble.
  - When `cnt == SCAN_DIV-1`: advance `digit` (2 wraps to 0) and go to BLANK. Otherwise increment `cnt`.
- **Hex decode.** Covers 0–F, active-low, standard glyphs, for example 0 → 7'b1000000, 1 → 7'b1111001, 8 → 7'b0000000, F → 7'b0001110.
- **Reset values.** Asserting `reset` at any time forces all state to its reset value asynchronously, including mid-transfer and mid-scan.
  - `shown` = 0, `prio` = proc, synced switches = 0.
  - FSM in BLANK with `digit = 0` and `cnt = 0`.
  - Outputs: `an = 3'b111`, `io_display = 7'h7F`, both `ready` = 0.

## Timing
- Switch change to effect on grants: 2 cycles.
- Grant in cycle N: `shown` is updated at edge N+1. The new value appears on a digit at that digit's next DRIVE slot.
- Scan period: 3 × (SCAN_DIV + 1) cycles, which is 15 at the default.
- After reset release: first edge enters DRIVE for digit 0.
- Outputs from the FSM and `shown` are registered-state driven. `ready` is combinational; no `ready → valid` loop is allowed inside the block.

## Structure
- Package `io_display_pkg` holds:
  - the scan state enum (BLANK, DRIVE);
  - the requester id enum (PROC, DBG);
  - localparams `AN_OFF = 3'b111` and `SEG_OFF = 7'h7F`.
- Sub-module `hex_to_7seg` is combinational: 4-bit nibble in, 7-bit active-low segments out.

## Test plan
- **Reset mid-scan.** Pulse `reset` low during DRIVE of digit 1 → `an = 111` and `io_display = 7F` immediately. After release, DRIVE digit 0 shows 0 (7'b1000000).
- **Single proc write.** `proc_valid = 1`, `proc_data = 12'h1A8` → `proc_ready = 1` for one cycle. `shown = 1A8` on the next edge. Digits show 8, A, 1 on `an` 110, 101, 011, with 1-cycle BLANK gaps and a 15-cycle period.
- **Contention.** Both valid, `sw = 2'b10` (synced), `prio = PROC`, proc = 123, dbg = 456 → proc granted first. Dbg is granted on the next cycle. Final `shown = 456`.
- **Freeze.** Hold `sw[0] = 1` (2 cycles to sync) with `proc_valid` = 1 and `proc_data` = 777 → `proc_ready` stays 0 and `shown` is unchanged. Release → grant 2 cycles later, `shown = 777`.
- **Debug disabled.** `sw = 2'b00`, `dbg_valid = 1` for 50 cycles → `dbg_ready` is never 1 and `shown` is unchanged.
- **Scan wrap.** Run 45 cycles after reset with `shown = FFF` → every DRIVE slot shows 7'b0001110. `digit` sequence is 0, 1, 2, 0, 1, 2…, with `an` never showing two low bits at once.
